// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver definitions.
// Contents:
//   state_t  - receiver FSM state encoding
//   mid_idx  - mid-bit sample index for a given oversampling ratio
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    function automatic int mid_idx(input int os);
        return os / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous inputs.
// Parameters:
//   WIDTH   - number of independent bits synchronized
//   RST_VAL - value both flops take during reset
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset
//   i_d  - asynchronous input
//   o_q  - synchronized output (two clk of latency)
module sync_2ff #(
    parameter int WIDTH   = 1,
    parameter bit RST_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= {WIDTH{RST_VAL}};
            r_q    <= {WIDTH{RST_VAL}};
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    always_comb o_q = r_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART byte receiver with majority-vote sampling.
// Optional macro RX_PARITY_EN adds an even-parity bit and the o_rx_perr port.
// Ports:
//   clk           - system clock; every flop runs on it
//   rst           - asynchronous active-high reset
//   i_sample_tick - one-clk enable at OVERSAMPLE x baud
//   i_rx_line     - raw asynchronous serial line, idle high
//   o_rx_byte     - last good byte, held until the next good frame
//   o_rx_valid    - one-clk pulse when o_rx_byte updates
//   o_rx_ferr     - one-clk pulse on a bad stop bit
//   o_rx_perr     - one-clk pulse on parity mismatch (RX_PARITY_EN only)
//   o_rx_busy     - high while a frame is in progress
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sample_tick,
    input  logic                 i_rx_line,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_rx_valid,
    output logic                 o_rx_ferr,
`ifdef RX_PARITY_EN
    output logic                 o_rx_perr,
`endif
    output logic                 o_rx_busy
);

    localparam int M  = mid_idx(OVERSAMPLE);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] C_END = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_S0  = CW'(M - 1);
    localparam logic [CW-1:0] C_S1  = CW'(M);
    localparam logic [CW-1:0] C_DEC = CW'(M + 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 w_line;
    state_t               r_state;
    state_t               w_nstate;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_byte;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 w_maj;
    logic                 w_end;
    logic                 w_dec;
    logic                 w_par_bad;
`ifdef RX_PARITY_EN
    logic                 r_par;
    logic                 r_perr;
`endif

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_rx_line),
        .o_q (w_line)
    );

    // Third sample is the live line value on the decision tick.
    always_comb begin
        w_maj = (r_s0 & r_s1) | (w_line & (r_s0 | r_s1));
        w_end = (r_cnt == C_END);
        w_dec = (r_cnt == C_DEC);
`ifdef RX_PARITY_EN
        w_par_bad = ^{r_shift, r_par};
`else
        w_par_bad = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        if (i_sample_tick) begin
            case (r_state)
                IDLE:      w_nstate = w_line ? IDLE : START;
                START:     w_nstate = (w_dec && w_maj) ? IDLE : (w_end ? DATA : START);
`ifdef RX_PARITY_EN
                DATA:      w_nstate = (w_end && r_bit == B_LAST) ? PARITY : DATA;
                PARITY:    w_nstate = w_end ? STOP : PARITY;
`else
                DATA:      w_nstate = (w_end && r_bit == B_LAST) ? STOP : DATA;
`endif
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                STOP:      w_nstate = w_dec ? (w_maj ? IDLE : WAIT_HIGH) : STOP;
                WAIT_HIGH: w_nstate = w_line ? IDLE : WAIT_HIGH;
                default:   w_nstate = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_s0    <= 1'b1;
            r_s1    <= 1'b1;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            if (i_sample_tick) begin
                // The start-detect tick is sample 0, so entering START loads 1.
                r_cnt <= (r_state == IDLE || r_state == WAIT_HIGH || w_nstate != r_state)
                       ? ((w_nstate == START) ? CW'(1) : '0)
                       : (w_end ? '0 : r_cnt + CW'(1));
                if (r_cnt == C_S0)
                    r_s0 <= w_line;
                if (r_cnt == C_S1)
                    r_s1 <= w_line;
                if (r_state == START)
                    r_bit <= '0;
                if (r_state == DATA && w_dec)
                    r_shift <= (DATA_BITS'(w_maj) << (DATA_BITS - 1)) | (r_shift >> 1);
                if (r_state == DATA && w_end)
                    r_bit <= (r_bit == B_LAST) ? '0 : r_bit + BW'(1);
`ifdef RX_PARITY_EN
                if (r_state == PARITY && w_dec)
                    r_par <= w_maj;
`endif
                if (r_state == STOP && w_dec) begin
                    r_ferr  <= !w_maj;
                    r_valid <= w_maj && !w_par_bad;
`ifdef RX_PARITY_EN
                    r_perr  <= w_maj && w_par_bad;
`endif
                    if (w_maj && !w_par_bad)
                        r_byte <= r_shift;
                end
            end
        end
    end

    always_comb begin
        o_rx_byte  = r_byte;
        o_rx_valid = r_valid;
        o_rx_ferr  = r_ferr;
`ifdef RX_PARITY_EN
        o_rx_perr  = r_perr;
`endif
        o_rx_busy  = (r_state != IDLE);
    end

endmodule
